// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory front end: FSM state encodings, owner encoding
// and default widths.
package mem_arbiter_pkg;

  localparam int DEF_M_WIDTH    = 8;
  localparam int DEF_INST_WIDTH = 2 * DEF_M_WIDTH;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_I_LO = 3'd1;
  localparam logic [2:0] ST_I_HI = 3'd2;
  localparam logic [2:0] ST_D_RD = 3'd3;
  localparam logic [2:0] ST_D_WR = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  // Owner value doubles as the client's bit index in the request/grant vectors.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter_2.sv
// Two-client round-robin arbiter: combinational, one-hot grant, favours the client
// that was not granted last when both request.
module rr_arbiter_2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  // NOTE: assign every combinational output a default first so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == OWNER_D) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory front end shared by fetch (I) and load/store (D): round-robin grant,
// one transaction at a time, 16-bit instructions assembled from two little-endian beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int M_WIDTH    = DEF_M_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [M_WIDTH-1:0]    i_addr,
  output logic [INST_WIDTH-1:0] i_data,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [M_WIDTH-1:0]    d_addr,
  input  logic [M_WIDTH-1:0]    d_wdata,
  output logic [M_WIDTH-1:0]    d_rdata,
  output logic                  d_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [M_WIDTH:0]      mem_addr,
  output logic [M_WIDTH-1:0]    mem_wdata,
  input  logic [M_WIDTH-1:0]    mem_rdata,
  input  logic                  mem_ack
);

  logic [2:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [M_WIDTH-1:0]    addr_q, addr_d;
  logic                  we_q, we_d;
  logic [M_WIDTH-1:0]    wdata_q, wdata_d;
  logic [INST_WIDTH-1:0] i_data_q, i_data_d;
  logic [M_WIDTH-1:0]    d_rdata_q, d_rdata_d;
  logic [1:0]            grant;

  rr_arbiter_2 u_arb (
    .req        ({d_req, i_req}),
    .last_grant (last_grant_q),
    .en         (state_q == ST_IDLE),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    i_data_d     = i_data_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant[OWNER_I]) begin
          state_d      = ST_I_LO;
          owner_d      = OWNER_I;
          last_grant_d = OWNER_I;
          addr_d       = i_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
        end else if (grant[OWNER_D]) begin
          state_d      = d_we ? ST_D_WR : ST_D_RD;
          owner_d      = OWNER_D;
          last_grant_d = OWNER_D;
          addr_d       = d_addr;
          we_d         = d_we;
          wdata_d      = d_wdata;
        end
      end
      ST_I_LO: if (mem_ack) begin
        i_data_d[M_WIDTH-1:0] = mem_rdata;
        state_d               = ST_I_HI;
      end
      ST_I_HI: if (mem_ack) begin
        i_data_d[INST_WIDTH-1:M_WIDTH] = mem_rdata;
        state_d                        = ST_RESP;
      end
      ST_D_RD: if (mem_ack) begin
        d_rdata_d = mem_rdata;
        state_d   = ST_RESP;
      end
      ST_D_WR: if (mem_ack) state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_D;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      i_data_q     <= i_data_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Memory-side signals depend only on state and captured fields, so they stay stable until ack.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_I_LO: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q, 1'b0};
      end
      ST_I_HI: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q, 1'b1};
      end
      ST_D_RD: begin
        mem_en   = 1'b1;
        mem_addr = {1'b0, addr_q};
      end
      ST_D_WR: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = {1'b0, addr_q};
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign i_ready = (state_q == ST_RESP) && (owner_q == OWNER_I);
  assign d_ready = (state_q == ST_RESP) && (owner_q == OWNER_D);
  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: client drivers push expected read data, a monitor
// pops on each ready pulse; a wait-state memory responder serves the memory port.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_req = 1'b0;
  logic [7:0] i_addr = '0;
  logic [15:0] i_data;
  logic       i_ready;
  logic       d_req = 1'b0;
  logic       d_we = 1'b0;
  logic [7:0] d_addr = '0;
  logic [7:0] d_wdata = '0;
  logic [7:0] d_rdata;
  logic       d_ready;
  logic       mem_en;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  sim_mem [0:511];   // memory behind the DUT port
  logic [7:0]  ref_mem [0:511];   // reference contents seen by the model
  logic [15:0] iq [$];
  logic [7:0]  dq [$];
  logic [7:0]  model_d = '0;      // d_rdata the model expects to be held
  int          wait_q [$];
  int          fixed_wait = 0;    // <0 selects random wait states
  logic [8:0]  ack_addr_q [$];
  logic        ack_we_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_wait();
    if (wait_q.size() != 0) return wait_q.pop_front();
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(0, 3));
  endfunction

  // Memory responder: counts wait states per beat, answers on the falling edge.
  initial begin : responder
    bit busy = 0;
    int wcnt = 0;
    int cur_wait = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy    = 0;
      end
      if (!rst || !mem_en) begin
        mem_ack = 1'b0;
        busy    = 0;
      end else begin
        if (!busy) begin
          busy     = 1;
          wcnt     = 0;
          cur_wait = pick_wait();
        end
        if (wcnt >= cur_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = sim_mem[mem_addr];
          if (mem_we) sim_mem[mem_addr] = mem_wdata;
          ack_addr_q.push_back(mem_addr);
          ack_we_q.push_back(mem_we);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (i_ready) begin
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL i_ready_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else check("i_data", i_data, iq.pop_front());
      end
      if (d_ready) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL d_ready_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else check("d_rdata", d_rdata, dq.pop_front());
      end
    end
  end

  task automatic fetch(input logic [7:0] a, output int lat, output int rcyc);
    bit done = 0;
    i_addr = a;
    i_req  = 1'b1;
    iq.push_back({ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]});
    lat  = 1;
    rcyc = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (i_ready) begin
        done = 1;
        rcyc = cyc;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL fetch_timeout: got no i_ready expected pulse addr=%0h", a);
    end
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  task automatic data_op(input bit we, input logic [7:0] a, input logic [7:0] wd,
                         input bit drop, output int lat, output int rcyc);
    bit done = 0;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    if (we) ref_mem[{1'b0, a}] = wd;
    else    model_d = ref_mem[{1'b0, a}];
    dq.push_back(model_d);
    lat  = 1;
    rcyc = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (d_ready) begin
        done = 1;
        rcyc = cyc;
      end else begin
        @(posedge clk);
        lat++;
        if (drop) #1 d_req = 1'b0;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL data_timeout: got no d_ready expected pulse addr=%0h", a);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int li, ld, ci, cd, en_seen;
    bit found;
    for (int k = 0; k < 512; k++) begin
      sim_mem[k] = 8'($urandom);
      ref_mem[k] = sim_mem[k];
    end
    sim_mem[9'h00A] = 8'h34; ref_mem[9'h00A] = 8'h34;
    sim_mem[9'h00B] = 8'h12; ref_mem[9'h00B] = 8'h12;
    sim_mem[9'h010] = 8'h7E; ref_mem[9'h010] = 8'h7E;

    repeat (3) @(posedge clk);
    #1;
    check("rst_i_data", i_data, 16'h0000);
    check("rst_d_rdata", d_rdata, 8'h00);
    check("rst_outputs", {i_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata}, '0);
    rst = 1'b1;

    // Simultaneous requests: I first after reset, D right after RESP, I first again.
    for (int p = 0; p < 2; p++) begin
      fork
        fetch(8'h20 + 8'(p), li, ci);
        data_op(1'b0, 8'h30 + 8'(p), 8'h00, 1'b0, ld, cd);
      join
      check("arb_i_first", 32'(ci < cd), 1);
      check("arb_d_gap", 32'(cd - ci), 3);
    end

    // Fetch 0x05 with immediate ack: bytes 0x0A then 0x0B, 4-cycle latency.
    ack_addr_q.delete(); ack_we_q.delete();
    fetch(8'h05, li, ci);
    check("fetch_latency", li, 4);
    check("fetch_beats", ack_addr_q.size(), 2);
    if (ack_addr_q.size() == 2) begin
      check("fetch_lo_addr", ack_addr_q[0], 9'h00A);
      check("fetch_hi_addr", ack_addr_q[1], 9'h00B);
    end
    repeat (3) @(posedge clk);
    #1 check("fetch_hold", i_data, 16'h1234);

    // Store with two wait states: 5-cycle latency, write lands at 0x080.
    ack_addr_q.delete(); ack_we_q.delete();
    wait_q.push_back(2);
    data_op(1'b1, 8'h80, 8'hA5, 1'b0, ld, cd);
    check("store_latency", ld, 5);
    check("store_beats", ack_addr_q.size(), 1);
    if (ack_addr_q.size() == 1) begin
      check("store_addr", ack_addr_q[0], 9'h080);
      check("store_we", ack_we_q[0], 1'b1);
    end
    check("store_mem", sim_mem[9'h080], 8'hA5);
    check("store_i_hold", i_data, 16'h1234);

    // Load with request dropped after grant still completes.
    data_op(1'b0, 8'h10, 8'h00, 1'b1, ld, cd);
    check("drop_latency", ld, 3);
    check("drop_rdata", d_rdata, 8'h7E);

    // Request still high during RESP must not start a second transaction.
    fetch(8'h06, li, ci);
    en_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_en) en_seen++;
    end
    check("no_regrant", en_seen, 0);

    // Reset while waiting in the high beat.
    wait_q.push_back(0);
    wait_q.push_back(1000);
    i_addr = 8'h07;
    i_req  = 1'b1;
    found  = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (mem_en && mem_addr == 9'h00F) found = 1;
    end
    check("reach_i_hi", found, 1'b1);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    i_req = 1'b0;
    #1;
    check("midrst_i_data", i_data, 16'h0000);
    check("midrst_mem_en", mem_en, 1'b0);
    check("midrst_d_rdata", d_rdata, 8'h00);
    wait_q.delete();
    model_d = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    en_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_en) en_seen++;
    end
    check("postrst_idle", en_seen, 0);

    // Randomized traffic: fetches use bytes 0x100-0x1FF, data uses 0x000-0x0FF.
    fixed_wait = -1;
    fork
      begin
        int l, c;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 fetch(8'($urandom_range(8'h80, 8'hFF)), l, c);
        end
      end
      begin
        int l, c;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 data_op(1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom), 1'b0, l, c);
        end
      end
    join
    repeat (4) @(posedge clk);
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
